// File: rtl/pid_pwm_out_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pid_pwm_out_pkg
// Purpose  : Shared widths, limits and helpers for the PID output/PWM stage.
// Revision : 1.0 - initial release
// ============================================================================
package pid_pwm_out_pkg;

    localparam int CONTRIB_W   = 6;
    localparam int SUM_W       = 8;
    localparam int PWM_W       = 6;
    localparam int U_MAX       = 31;
    localparam int U_MIN       = -32;
    localparam int DUTY_OFFSET = 32;

    typedef logic signed [CONTRIB_W-1:0] contrib_t;
    typedef logic signed [SUM_W-1:0]     sum_t;

    typedef struct packed {
        contrib_t u;
        logic     sat;
    } sat_t;

    function automatic sum_t sext(input contrib_t v);
        return {{(SUM_W-CONTRIB_W){v[CONTRIB_W-1]}}, v};
    endfunction

    function automatic sat_t saturate(input sum_t s);
        sat_t r;
        r.u   = s[CONTRIB_W-1:0];
        r.sat = 1'b0;
        if (s > sum_t'(U_MAX)) begin
            r.u   = contrib_t'(U_MAX);
            r.sat = 1'b1;
        end else if (s < sum_t'(U_MIN)) begin
            r.u   = contrib_t'(U_MIN);
            r.sat = 1'b1;
        end
        return r;
    endfunction

    // Modulo-64 add of the offset maps -32..31 onto 0..63 (offset binary).
    function automatic logic [PWM_W-1:0] to_duty(input contrib_t u);
        logic [PWM_W-1:0] b;
        b = PWM_W'(u);
        return b + PWM_W'(DUTY_OFFSET);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pid_pwm_out_pwm_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_gen
// Purpose  : 64-cycle PWM counter with shadowed duty, compare and period pulse.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_gen
    import pid_pwm_out_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [PWM_W-1:0] duty_next,
    output logic             pwm,
    output logic             period_start
);

    localparam logic [PWM_W-1:0] c_cnt_last = '1;

    logic [PWM_W-1:0] r_cnt;
    logic [PWM_W-1:0] r_duty;
    logic             r_pwm;
    logic             r_ps;
    logic [PWM_W-1:0] w_cnt_next;
    logic [PWM_W-1:0] w_duty_next;
    logic             w_wrap;

    // The compare uses next-state values so the registered pwm matches the
    // counter value it is shown alongside, including the freshly loaded duty.
    always_comb begin
        w_wrap      = (r_cnt == c_cnt_last);
        w_cnt_next  = r_cnt + PWM_W'(1);
        w_duty_next = w_wrap ? duty_next : r_duty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_duty <= '0;
            r_pwm  <= 1'b0;
            r_ps   <= 1'b0;
        end else if (ena) begin
            r_cnt  <= w_cnt_next;
            r_duty <= w_duty_next;
            r_pwm  <= (w_cnt_next < w_duty_next);
            r_ps   <= (w_cnt_next == '0);
        end
    end

    assign pwm          = r_pwm;
    // Gating by ena keeps the pulse to a single enabled cycle across stalls.
    assign period_start = r_ps & ena;

endmodule
`default_nettype wire

// File: rtl/pid_pwm_out.sv
`default_nettype none
// ============================================================================
// Module   : pid_pwm_out
// Purpose  : Sums P/I/D contributions, saturates, registers and drives a PWM.
// Revision : 1.0 - initial release
// ============================================================================
module pid_pwm_out
    import pid_pwm_out_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic signed [CONTRIB_W-1:0] p_contrib,
    input  logic signed [CONTRIB_W-1:0] i_contrib,
    input  logic signed [CONTRIB_W-1:0] d_contrib,
    output logic signed [CONTRIB_W-1:0] u_out,
    output logic                        sat,
    output logic                        pwm,
    output logic                        period_start
);

    sum_t             w_sum;
    sat_t             w_sat;
    logic [PWM_W-1:0] w_duty;
    contrib_t         r_u;
    logic             r_sat;

    // Eight bits hold the full -96..93 range of three 6-bit terms.
    always_comb begin
        w_sum  = sext(p_contrib) + sext(i_contrib) + sext(d_contrib);
        w_sat  = saturate(w_sum);
        w_duty = to_duty(r_u);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_u   <= '0;
            r_sat <= 1'b0;
        end else if (ena) begin
            r_u   <= w_sat.u;
            r_sat <= w_sat.sat;
        end
    end

    assign u_out = r_u;
    assign sat   = r_sat;

    pwm_gen u_pwm_gen (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .duty_next    (w_duty),
        .pwm          (pwm),
        .period_start (period_start)
    );

endmodule
`default_nettype wire

// File: tb/tb_pid_pwm_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_pid_pwm_out
// Purpose  : Directed self-checking bench for pid_pwm_out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pid_pwm_out;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ena;
    logic signed [5:0] p_contrib;
    logic signed [5:0] i_contrib;
    logic signed [5:0] d_contrib;
    logic signed [5:0] u_out;
    logic              sat;
    logic              pwm;
    logic              period_start;

    pid_pwm_out dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .p_contrib    (p_contrib),
        .i_contrib    (i_contrib),
        .d_contrib    (d_contrib),
        .u_out        (u_out),
        .sat          (sat),
        .pwm          (pwm),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int u;
        int s;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   g_highs;
    int   g_pulses;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_n(input int n);
        for (int k = 0; k < n; k++) begin
            g_highs  += (pwm === 1'b1) ? 1 : 0;
            g_pulses += (period_start === 1'b1) ? 1 : 0;
            step();
        end
    endtask

    task automatic clr_acc();
        g_highs  = 0;
        g_pulses = 0;
    endtask

    // Drive contributions and queue the saturated result expected next cycle.
    task automatic drive(input int pv, input int iv, input int dv);
        exp_t e;
        int   s;
        p_contrib = pv[5:0];
        i_contrib = iv[5:0];
        d_contrib = dv[5:0];
        s   = pv + iv + dv;
        e.u = (s > 31) ? 31 : (s < -32) ? -32 : s;
        e.s = (s > 31 || s < -32) ? 1 : 0;
        sb.push_back(e);
    endtask

    task automatic check_u(input string tag);
        exp_t e;
        chk({tag, "_sb"}, sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_u"}, $signed(u_out), e.u);
            chk({tag, "_sat"}, sat, e.s);
        end
    endtask

    task automatic sat_vec(input string tag, input int pv, input int iv, input int dv);
        drive(pv, iv, dv);
        run_n(1);
        check_u(tag);
    endtask

    initial begin
        int idx[$];
        rst_n     = 1'b0;
        ena       = 1'b1;
        p_contrib = '0;
        i_contrib = '0;
        d_contrib = '0;
        #8;
        chk("rst_u", $signed(u_out), 0);
        chk("rst_sat", sat, 0);
        chk("rst_pwm", pwm, 0);
        chk("rst_ps", period_start, 0);
        #4;
        rst_n = 1'b1;

        // First period after reset: saturation vectors, pwm must stay low.
        clr_acc();
        sat_vec("sat_pos", 31, 31, 31);
        sat_vec("sat_neg", -32, -32, 0);
        sat_vec("sat_mix", 5, -3, 1);
        sat_vec("sat_max_edge", 10, 10, 11);
        sat_vec("sat_over_edge", 10, 10, 12);
        sat_vec("sat_min_edge", -10, -10, -12);
        sat_vec("sat_under_edge", -10, -10, -13);
        sat_vec("sat_full_neg", -32, -32, -32);
        sat_vec("sat_zero", 0, 0, 0);
        run_n(55);
        chk("p1_highs", g_highs, 0);
        chk("p1_pulses", g_pulses, 0);
        chk("p2_start", period_start, 1);

        // Duty 32 from u_out=0; queue u=-32 for the next period.
        clr_acc();
        sat_vec("p2_drive", -32, 0, 0);
        run_n(63);
        chk("p2_highs", g_highs, 32);
        chk("p2_pulses", g_pulses, 1);

        clr_acc();
        sat_vec("p3_drive", 31, 0, 0);
        run_n(63);
        chk("p3_highs", g_highs, 0);
        chk("p3_pulses", g_pulses, 1);

        clr_acc();
        sat_vec("p4_drive", 0, 0, 0);
        run_n(63);
        chk("p4_highs", g_highs, 63);
        chk("p4_pulses", g_pulses, 1);

        // Shadow: u_out moves 0 -> 16 mid-period.
        clr_acc();
        run_n(20);
        sat_vec("p5_drive", 16, 0, 0);
        run_n(43);
        chk("p5_highs", g_highs, 32);
        chk("p5_pulses", g_pulses, 1);

        clr_acc();
        run_n(64);
        chk("p6_highs", g_highs, 48);
        chk("p6_pulses", g_pulses, 1);

        // Enable stall at counter 40 with duty 48.
        clr_acc();
        run_n(40);
        chk("en_pwm_before", pwm, 1);
        ena       = 1'b0;
        p_contrib = -6'sd5;
        for (int k = 0; k < 10; k++) begin
            step();
            chk("en_pwm_hold", pwm, 1);
            chk("en_ps_low", period_start, 0);
            chk("en_u_hold", $signed(u_out), 16);
        end
        p_contrib = 6'sd16;
        ena       = 1'b1;
        run_n(24);
        chk("p7_highs", g_highs, 48);
        chk("p7_pulses", g_pulses, 1);
        chk("p8_start", period_start, 1);

        // Stall on the wrap cycle must defer, not drop, the shadow load.
        clr_acc();
        run_n(10);
        sat_vec("p8_drive", 0, 0, 0);
        run_n(52);
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("wrap_ps_low", period_start, 0);
            chk("wrap_pwm_hold", pwm, 0);
        end
        ena = 1'b1;
        run_n(1);
        chk("p8_highs", g_highs, 48);
        chk("p8_pulses", g_pulses, 1);

        clr_acc();
        run_n(64);
        chk("p9_highs", g_highs, 32);
        chk("p9_pulses", g_pulses, 1);

        // Three free-running periods.
        for (int k = 0; k < 192; k++) begin
            if (period_start === 1'b1) idx.push_back(k);
            step();
        end
        chk("ps_count", idx.size(), 3);
        if (idx.size() == 3) begin
            chk("ps_first", idx[0], 0);
            chk("ps_gap1", idx[1] - idx[0], 64);
            chk("ps_gap2", idx[2] - idx[1], 64);
        end

        // Asynchronous reset mid-period while pwm is high.
        sat_vec("pre_rst_drive", 31, 31, 0);
        run_n(9);
        chk("pre_rst_pwm", pwm, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_u", $signed(u_out), 0);
        chk("arst_sat", sat, 0);
        chk("arst_pwm", pwm, 0);
        chk("arst_ps", period_start, 0);
        p_contrib = '0;
        i_contrib = '0;
        d_contrib = '0;
        #3;
        rst_n = 1'b1;
        clr_acc();
        run_n(64);
        chk("post_rst_highs", g_highs, 0);
        chk("post_rst_pulses", g_pulses, 0);
        chk("post_rst_start", period_start, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
